// File: rtl/light_monitor.sv
// Traffic-light lamp monitor: synchronizes lamp lines, tracks phase order, flags faults.
// Optional stall detection is built when LIGHT_MONITOR_STALL_EN is defined.
module light_monitor #(
    parameter int STALL_LIMIT = 100000000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic [5:0] lights_in,
    input  logic       clr_fault,
    output logic [2:0] phase,
    output logic       phase_valid,
    output logic       seq_err,
    output logic       fault,
    output logic       stall,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        TRACK     = 2'd1,
        FAULT     = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [5:0] sync1;
    logic [5:0] sync2;
    logic [5:0] sync3;
    logic [5:0] accepted;
    logic       accept;
    logic       legal;
    logic [2:0] dec_phase;
    logic [2:0] exp_phase;
    logic       seq_hit;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            accepted <= '0;
        end else begin
            sync1 <= lights_in;
            sync2 <= sync1;
            sync3 <= sync2;
            if (accept)
                accepted <= sync2;
        end
    end

    // A value must survive two synchronized samples before it counts
    assign accept = (sync2 == sync3) && (sync2 != accepted);

    always_comb begin
        legal     = 1'b1;
        dec_phase = 3'd0;
        case (sync2)
            6'b100001: dec_phase = 3'd0;
            6'b100010: dec_phase = 3'd1;
            6'b100100: dec_phase = (phase == 3'd4) ? 3'd5 : 3'd2;
            6'b001100: dec_phase = 3'd3;
            6'b010100: dec_phase = 3'd4;
            default:   legal     = 1'b0;
        endcase
    end

    assign exp_phase = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
    assign seq_hit   = accept && legal && (state == TRACK)
                       && (dec_phase != exp_phase);

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst)
            state <= SYNC_WAIT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SYNC_WAIT: begin
                if (accept && !legal)
                    state_nx = FAULT;
                else if (accept)
                    state_nx = TRACK;
            end
            TRACK: begin
                if (accept && !legal)
                    state_nx = FAULT;
            end
            FAULT: begin
                // A new illegal pattern outranks a same-cycle release
                if (accept && !legal)
                    state_nx = FAULT;
                else if (clr_fault)
                    state_nx = SYNC_WAIT;
            end
            default: state_nx = SYNC_WAIT;
        endcase
    end

    always_comb begin
        phase_valid = (state == TRACK);
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            phase     <= 3'd0;
            seq_err   <= 1'b0;
            fault     <= 1'b0;
            err_count <= 8'd0;
        end else begin
            seq_err <= seq_hit;
            if (seq_hit && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (accept && legal && state != FAULT)
                phase <= dec_phase;
            if (accept && !legal)
                fault <= 1'b1;
            else if (state == FAULT && clr_fault)
                fault <= 1'b0;
        end
    end

`ifdef LIGHT_MONITOR_STALL_EN
    localparam logic [26:0] LIMIT = 27'(STALL_LIMIT);

    logic [26:0] dwell;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst)
            dwell <= '0;
        else if (accept || state != TRACK)
            dwell <= '0;
        else if (dwell != LIMIT)
            dwell <= dwell + 27'd1;
    end

    assign stall = (dwell == LIMIT);
`else
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_light_monitor.sv
// Directed scoreboard bench for light_monitor.
// Stall checks follow LIGHT_MONITOR_STALL_EN.
module tb_light_monitor;

    typedef struct packed {
        logic [2:0] ph;
        logic       vld;
        logic       flt;
        logic       seq;
        logic [7:0] err;
    } exp_t;

    localparam logic [5:0] P0 = 6'b100001;
    localparam logic [5:0] P1 = 6'b100010;
    localparam logic [5:0] P2 = 6'b100100;
    localparam logic [5:0] P3 = 6'b001100;
    localparam logic [5:0] P4 = 6'b010100;
    localparam logic [5:0] P5 = 6'b100100;

`ifdef LIGHT_MONITOR_STALL_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] lights_in;
    logic       clr_fault;
    logic [2:0] phase;
    logic       phase_valid;
    logic       seq_err;
    logic       fault;
    logic       stall;
    logic [7:0] err_count;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [2:0] cur_phase = 3'd0;
    exp_t       sb[$];

    light_monitor #(.STALL_LIMIT(20)) dut (
        .CLOCK_50   (clk),
        .rst        (rst),
        .lights_in  (lights_in),
        .clr_fault  (clr_fault),
        .phase      (phase),
        .phase_valid(phase_valid),
        .seq_err    (seq_err),
        .fault      (fault),
        .stall      (stall),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] ph, input logic vld,
                                input logic flt, input logic seq,
                                input logic [7:0] err);
        exp_t e;
        e.ph  = ph;
        e.vld = vld;
        e.flt = flt;
        e.seq = seq;
        e.err = err;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, "_phase"}, 32'(phase), 32'(e.ph));
        chk({tag, "_valid"}, 32'(phase_valid), 32'(e.vld));
        chk({tag, "_fault"}, 32'(fault), 32'(e.flt));
        chk({tag, "_seq"}, 32'(seq_err), 32'(e.seq));
        chk({tag, "_errcnt"}, 32'(err_count), 32'(e.err));
    endtask

    // Drive a pattern, expect the result exactly 4 edges later
    task automatic step(input string tag, input logic [5:0] pat,
                        input int hold, input exp_t e);
        exp_t got;
        @(negedge clk);
        lights_in = pat;
        sb.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_early_phase"}, 32'(phase), 32'(cur_phase));
        chk({tag, "_early_seq"}, 32'(seq_err), 32'd0);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s_sb: observed empty expected entry", tag);
        end else begin
            got = sb.pop_front();
            chk_out(tag, got);
            cur_phase = got.ph;
        end
        repeat (hold - 4) begin
            @(posedge clk);
            #1;
            chk({tag, "_seq_idle"}, 32'(seq_err), 32'd0);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        lights_in = 6'b0;
        clr_fault = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", mk(3'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        chk("reset_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Legal full cycle, no errors
        step("seq0", P0, 10, mk(3'd0, 1'b1, 1'b0, 1'b0, 8'd0));
        step("seq1", P1, 10, mk(3'd1, 1'b1, 1'b0, 1'b0, 8'd0));
        step("seq2", P2, 10, mk(3'd2, 1'b1, 1'b0, 1'b0, 8'd0));
        step("seq3", P3, 10, mk(3'd3, 1'b1, 1'b0, 1'b0, 8'd0));
        step("seq4", P4, 10, mk(3'd4, 1'b1, 1'b0, 1'b0, 8'd0));
        step("seq5", P5, 10, mk(3'd5, 1'b1, 1'b0, 1'b0, 8'd0));
        step("seq0b", P0, 10, mk(3'd0, 1'b1, 1'b0, 1'b0, 8'd0));

        // Skip from 1 to 3
        step("skip1", P1, 10, mk(3'd1, 1'b1, 1'b0, 1'b0, 8'd0));
        step("skip3", P3, 10, mk(3'd3, 1'b1, 1'b0, 1'b1, 8'd1));
        step("skip4", P4, 10, mk(3'd4, 1'b1, 1'b0, 1'b0, 8'd1));

        // Single-cycle glitch
        @(negedge clk);
        lights_in = 6'b001001;
        @(negedge clk);
        lights_in = P4;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk_out("glitch", mk(3'd4, 1'b1, 1'b0, 1'b0, 8'd1));
        end

        // Illegal all-ones
        step("ones", 6'h3F, 5, mk(3'd4, 1'b0, 1'b1, 1'b0, 8'd1));
        chk("ones_stall", 32'(stall), 32'd0);

        // Release and new illegal acceptance on the same edge
        @(negedge clk);
        lights_in = 6'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr_fault = 1'b1;
        @(posedge clk);
        #1;
        chk_out("clr_race", mk(3'd4, 1'b0, 1'b1, 1'b0, 8'd1));
        @(negedge clk);
        clr_fault = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("clr_race_hold", mk(3'd4, 1'b0, 1'b1, 1'b0, 8'd1));

        pulse_clr();
        chk_out("clr", mk(3'd4, 1'b0, 1'b0, 1'b0, 8'd1));

        // Resync: 4 -> 0 is not an error from SYNC_WAIT
        step("resync", P0, 10, mk(3'd0, 1'b1, 1'b0, 1'b0, 8'd1));

        // Dwell / stall
        step("dwell", P1, 4, mk(3'd1, 1'b1, 1'b0, 1'b0, 8'd1));
        repeat (19) @(posedge clk);
        #1;
        chk("stall_19", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        chk("stall_20", 32'(stall), 32'(STALL_ON));
        repeat (5) @(posedge clk);
        #1;
        chk("stall_25", 32'(stall), 32'(STALL_ON));
        step("unstall", P2, 10, mk(3'd2, 1'b1, 1'b0, 1'b0, 8'd1));
        chk("stall_clr", 32'(stall), 32'd0);

        // Saturation of err_count
        for (int i = 0; i < 260; i++) begin
            int c;
            c = (2 + i > 255) ? 255 : 2 + i;
            if (i % 2 == 0)
                step("sat", P0, 4, mk(3'd0, 1'b1, 1'b0, 1'b1, 8'(c)));
            else
                step("sat", P3, 4, mk(3'd3, 1'b1, 1'b0, 1'b1, 8'(c)));
        end
        @(posedge clk);
        #1;
        chk("sat_final", 32'(err_count), 32'd255);
        chk("sat_seq_off", 32'(seq_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
